store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer_if.sv | 39 +++
 rtl/store_buffer.sv | 149 ++++++++++++++
 tb/tb_store_buffer.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/store_buffer_if.sv
// Processor MEM-stage and external-memory signal bundle for the store buffer.
// The slave view belongs to the buffer; the master view is the surroundings
// (pipeline plus memory) that drive it.
interface store_buffer_if;
    // processor side
    logic [0:31] proc_addr;
    logic [31:0] proc_wdata;
    logic        proc_we;
    logic        proc_re;
    logic        proc_byte;
    logic        proc_half_word;
    logic        proc_sign_extend;
    logic [31:0] proc_rdata;
    logic        proc_stall;
    // memory side
    logic        mem_req;
    logic        mem_we;
    logic [0:31] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_byte;
    logic        mem_half_word;
    logic        mem_sign_extend;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport slave (
        input  proc_addr, proc_wdata, proc_we, proc_re, proc_byte,
               proc_half_word, proc_sign_extend, mem_ack, mem_rdata,
        output proc_rdata, proc_stall, mem_req, mem_we, mem_addr,
               mem_wdata, mem_byte, mem_half_word, mem_sign_extend
    );

    modport master (
        output proc_addr, proc_wdata, proc_we, proc_re, proc_byte,
               proc_half_word, proc_sign_extend, mem_ack, mem_rdata,
        input  proc_rdata, proc_stall, mem_req, mem_we, mem_addr,
               mem_wdata, mem_byte, mem_half_word, mem_sign_extend
    );
endinterface

// File: rtl/store_buffer.sv
// Store buffer: absorbs processor stores into a small circular FIFO and
// drains them to memory in the background. Loads that hit a buffered word
// first force the buffer to drain until the hit is gone; loads that miss
// bypass the queued stores and go to memory straight away.
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic          clock,
    input  logic          reset,
    store_buffer_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, DRAIN, LOAD} state_t;

    typedef struct packed {
        logic [0:31] addr;
        logic [31:0] wdata;
        logic        is_byte;
        logic        is_half;
    } entry_t;

    state_t        state_q;
    logic [PW-1:0] head_q;
    logic [PW-1:0] tail_q;
    logic [CW-1:0] count_q;
    entry_t        fifo_q [DEPTH];

    logic        mem_req_q;
    logic        mem_we_q;
    logic [0:31] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic        mem_byte_q;
    logic        mem_half_q;
    logic        mem_sext_q;

    logic             full;
    logic             enq;
    logic             deq;
    logic             load_req;
    logic             match;
    logic [DEPTH-1:0] hit;

    assign full     = (count_q == CW'(DEPTH));
    assign enq      = bus.proc_we & ~full;
    assign deq      = (state_q == DRAIN) & bus.mem_ack;
    // A simultaneous store and load is handled purely as a store.
    assign load_req = bus.proc_re & ~bus.proc_we;

    // Word-address compare against every entry that lies between head and tail.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
        logic [PW-1:0] offset;
        assign offset  = PW'(gi) - head_q;
        assign hit[gi] = (CW'(offset) < count_q) &&
                         (fifo_q[gi].addr[0:29] == bus.proc_addr[0:29]);
    end
    assign match = |hit;

    assign bus.proc_stall = (bus.proc_we & full) |
                            (load_req & ~((state_q == LOAD) & bus.mem_ack));
    assign bus.proc_rdata = ((state_q == LOAD) && bus.mem_ack) ? bus.mem_rdata : 32'b0;

    assign bus.mem_req         = mem_req_q;
    assign bus.mem_we          = mem_we_q;
    assign bus.mem_addr        = mem_addr_q;
    assign bus.mem_wdata       = mem_wdata_q;
    assign bus.mem_byte        = mem_byte_q;
    assign bus.mem_half_word   = mem_half_q;
    assign bus.mem_sign_extend = mem_sext_q;

    // Entry storage: written at the tail on every accepted store; contents
    // need no reset because validity comes from head/count.
    always_ff @(posedge clock) begin
        if (enq) begin
            fifo_q[tail_q] <= '{addr:    bus.proc_addr,
                                wdata:   bus.proc_wdata,
                                is_byte: bus.proc_byte,
                                is_half: bus.proc_half_word};
        end
    end

    // Pointer/count bookkeeping plus the IDLE/DRAIN/LOAD controller with
    // registered memory-request outputs (held stable until mem_ack).
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_byte_q  <= 1'b0;
            mem_half_q  <= 1'b0;
            mem_sext_q  <= 1'b0;
        end else begin
            if (enq) begin
                tail_q <= tail_q + 1'b1;
            end
            if (deq) begin
                head_q <= head_q + 1'b1;
            end
            count_q <= count_q + CW'(enq) - CW'(deq);

            case (state_q)
                IDLE: begin
                    if (load_req && !match) begin
                        state_q     <= LOAD;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= bus.proc_addr;
                        mem_wdata_q <= '0;
                        mem_byte_q  <= bus.proc_byte;
                        mem_half_q  <= bus.proc_half_word;
                        mem_sext_q  <= bus.proc_sign_extend;
                    end else if (count_q != '0) begin
                        state_q     <= DRAIN;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= fifo_q[head_q].addr;
                        mem_wdata_q <= fifo_q[head_q].wdata;
                        mem_byte_q  <= fifo_q[head_q].is_byte;
                        mem_half_q  <= fifo_q[head_q].is_half;
                        mem_sext_q  <= 1'b0;
                    end
                end
                DRAIN, LOAD: begin
                    if (bus.mem_ack) begin
                        state_q     <= IDLE;
                        mem_req_q   <= 1'b0;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= '0;
                        mem_wdata_q <= '0;
                        mem_byte_q  <= 1'b0;
                        mem_half_q  <= 1'b0;
                        mem_sext_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                    mem_we_q  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer (DEPTH=4): full-buffer stall, matched and
// unmatched loads, wrap-around draining in program order, reset mid-drain.
module tb_store_buffer;
    logic clock;
    logic reset;
    int   vectors;
    int   miscompares;

    logic [31:0] wr_addr_q [$];
    logic [31:0] wr_data_q [$];

    store_buffer_if bus ();

    store_buffer #(.DEPTH(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Record every completed memory write, sampled mid-cycle.
    always @(negedge clock) begin
        if (reset === 1'b1 && bus.mem_req === 1'b1 && bus.mem_we === 1'b1 && bus.mem_ack === 1'b1) begin
            wr_addr_q.push_back(bus.mem_addr);
            wr_data_q.push_back(bus.mem_wdata);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    // Wait (bounded) for a write request, check it, acknowledge it for one cycle.
    task automatic expect_write(input logic [31:0] a, input logic [31:0] d, input logic b, input string tag);
        int n = 0;
        while (bus.mem_req !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_req"}, 32'(bus.mem_req), 32'd1);
        chk({tag, "_we"}, 32'(bus.mem_we), 32'd1);
        chk({tag, "_addr"}, bus.mem_addr, a);
        chk({tag, "_wdata"}, bus.mem_wdata, d);
        chk({tag, "_byte"}, 32'(bus.mem_byte), 32'(b));
        chk({tag, "_sext"}, 32'(bus.mem_sign_extend), 32'd0);
        bus.mem_ack = 1'b1;
        step();
        bus.mem_ack = 1'b0;
    endtask

    // Wait (bounded) for a read request, check it, return data with ack.
    task automatic expect_load(input logic [31:0] a, input logic [31:0] rd, input logic sx,
                               input logic hw, input string tag);
        int n = 0;
        while (bus.mem_req !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_req"}, 32'(bus.mem_req), 32'd1);
        chk({tag, "_we"}, 32'(bus.mem_we), 32'd0);
        chk({tag, "_addr"}, bus.mem_addr, a);
        chk({tag, "_sext"}, 32'(bus.mem_sign_extend), 32'(sx));
        chk({tag, "_half"}, 32'(bus.mem_half_word), 32'(hw));
        bus.mem_rdata = rd;
        bus.mem_ack   = 1'b1;
        #1;
        chk({tag, "_rdata"}, bus.proc_rdata, rd);
        chk({tag, "_stall_ack"}, 32'(bus.proc_stall), 32'd0);
        step();
        bus.mem_ack   = 1'b0;
        bus.proc_re   = 1'b0;
        bus.mem_rdata = 32'h0;
        #1;
        chk({tag, "_rdata_after"}, bus.proc_rdata, 32'h0);
        chk({tag, "_req_after"}, 32'(bus.mem_req), 32'd0);
    endtask

    initial begin
        int idx_tbl [10];
        logic stall_tbl [10];
        int base;

        idx_tbl   = '{0, 1, 2, 3, 4, 5, 6, 6, 7, 7};
        stall_tbl = '{0, 0, 0, 0, 0, 0, 1, 0, 1, 0};
        vectors     = 0;
        miscompares = 0;

        bus.proc_addr        = '0;
        bus.proc_wdata       = '0;
        bus.proc_we          = 1'b0;
        bus.proc_re          = 1'b0;
        bus.proc_byte        = 1'b0;
        bus.proc_half_word   = 1'b0;
        bus.proc_sign_extend = 1'b0;
        bus.mem_ack          = 1'b0;
        bus.mem_rdata        = '0;
        reset                = 1'b0;

        // ---- reset state ----
        step();
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
        chk("rst_rdata", bus.proc_rdata, 32'h0);
        chk("rst_stall_idle", 32'(bus.proc_stall), 32'd0);
        bus.proc_re = 1'b1;
        #1;
        chk("rst_stall_load", 32'(bus.proc_stall), 32'd1);
        bus.proc_re = 1'b0;
        reset = 1'b1;
        step();

        // ---- four stores fill the buffer, fifth stalls until first ack ----
        for (int i = 0; i < 4; i++) begin
            bus.proc_we    = 1'b1;
            bus.proc_addr  = 32'h100 + 32'(4 * i);
            bus.proc_wdata = 32'h11 * 32'(i + 1);
            #1;
            chk("fill_stall", 32'(bus.proc_stall), 32'd0);
            if (i == 2) begin
                chk("fill_drain_req", 32'(bus.mem_req), 32'd1);
                chk("fill_drain_we", 32'(bus.mem_we), 32'd1);
                chk("fill_drain_addr", bus.mem_addr, 32'h100);
                chk("fill_drain_wdata", bus.mem_wdata, 32'h11);
            end
            step();
        end
        bus.proc_addr  = 32'h110;
        bus.proc_wdata = 32'h55;
        #1;
        chk("full_stall", 32'(bus.proc_stall), 32'd1);
        chk("full_head_held", bus.mem_addr, 32'h100);
        step();
        #1;
        chk("full_stall2", 32'(bus.proc_stall), 32'd1);
        bus.mem_ack = 1'b1;
        #1;
        chk("full_stall_ack", 32'(bus.proc_stall), 32'd1);
        step();
        bus.mem_ack = 1'b0;
        #1;
        chk("full_stall_released", 32'(bus.proc_stall), 32'd0);
        chk("full_idle_req", 32'(bus.mem_req), 32'd0);
        step();
        bus.proc_we = 1'b0;
        expect_write(32'h104, 32'h22, 1'b0, "fillw1");
        expect_write(32'h108, 32'h33, 1'b0, "fillw2");
        expect_write(32'h10C, 32'h44, 1'b0, "fillw3");
        expect_write(32'h110, 32'h55, 1'b0, "fillw4");
        step();
        step();
        chk("fill_empty_req", 32'(bus.mem_req), 32'd0);

        // ---- matched load: drain first, then load ----
        bus.proc_we    = 1'b1;
        bus.proc_addr  = 32'h200;
        bus.proc_wdata = 32'hDEADBEEF;
        step();
        bus.proc_we = 1'b0;
        bus.proc_re = 1'b1;
        #1;
        chk("hit_stall", 32'(bus.proc_stall), 32'd1);
        expect_write(32'h200, 32'hDEADBEEF, 1'b0, "hitw");
        expect_load(32'h200, 32'hCAFEF00D, 1'b0, 1'b0, "hitl");

        // ---- unmatched load bypasses queued store ----
        bus.proc_we    = 1'b1;
        bus.proc_byte  = 1'b1;
        bus.proc_addr  = 32'h300;
        bus.proc_wdata = 32'h3333;
        step();
        bus.proc_we          = 1'b0;
        bus.proc_byte        = 1'b0;
        bus.proc_re          = 1'b1;
        bus.proc_addr        = 32'h400;
        bus.proc_sign_extend = 1'b1;
        bus.proc_half_word   = 1'b1;
        #1;
        chk("miss_stall", 32'(bus.proc_stall), 32'd1);
        chk("miss_no_req_yet", 32'(bus.mem_req), 32'd0);
        expect_load(32'h400, 32'h12345678, 1'b1, 1'b1, "missl");
        bus.proc_sign_extend = 1'b0;
        bus.proc_half_word   = 1'b0;
        expect_write(32'h300, 32'h3333, 1'b1, "missw");

        // ---- store and load together is a store only ----
        bus.proc_we    = 1'b1;
        bus.proc_re    = 1'b1;
        bus.proc_addr  = 32'h700;
        bus.proc_wdata = 32'h77;
        #1;
        chk("we_re_stall", 32'(bus.proc_stall), 32'd0);
        step();
        bus.proc_we = 1'b0;
        bus.proc_re = 1'b0;
        expect_write(32'h700, 32'h77, 1'b0, "we_re_w");

        // ---- eight stores, ack every cycle: wrap and program order ----
        base = wr_addr_q.size();
        bus.mem_ack = 1'b1;
        for (int c = 0; c < 10; c++) begin
            bus.proc_we    = 1'b1;
            bus.proc_addr  = 32'h500 + 32'(4 * idx_tbl[c]);
            bus.proc_wdata = 32'hA0 + 32'(idx_tbl[c]);
            #1;
            chk($sformatf("wrap_stall_c%0d", c), 32'(bus.proc_stall), 32'(stall_tbl[c]));
            step();
        end
        bus.proc_we = 1'b0;
        repeat (10) step();
        bus.mem_ack = 1'b0;
        chk("wrap_write_count", 32'(wr_addr_q.size() - base), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (base + i < wr_addr_q.size()) begin
                chk($sformatf("wrap_addr%0d", i), wr_addr_q[base + i], 32'h500 + 32'(4 * i));
                chk($sformatf("wrap_data%0d", i), wr_data_q[base + i], 32'hA0 + 32'(i));
            end
        end

        // ---- reset during drain with three entries ----
        for (int i = 0; i < 3; i++) begin
            bus.proc_we    = 1'b1;
            bus.proc_addr  = 32'h600 + 32'(4 * i);
            bus.proc_wdata = 32'hB0 + 32'(i);
            step();
        end
        bus.proc_we = 1'b0;
        #1;
        chk("rdrain_req", 32'(bus.mem_req), 32'd1);
        chk("rdrain_addr", bus.mem_addr, 32'h600);
        base = wr_addr_q.size();
        reset = 1'b0;
        #1;
        chk("rdrain_req_cut", 32'(bus.mem_req), 32'd0);
        chk("rdrain_we_cut", 32'(bus.mem_we), 32'd0);
        chk("rdrain_addr_cut", bus.mem_addr, 32'h0);
        chk("rdrain_wdata_cut", bus.mem_wdata, 32'h0);
        step();
        reset = 1'b1;
        bus.mem_ack = 1'b1;
        repeat (6) step();
        chk("rdrain_no_writes", 32'(wr_addr_q.size() - base), 32'd0);
        chk("rdrain_idle_req", 32'(bus.mem_req), 32'd0);
        bus.mem_ack = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
